// File: rtl/read_hs_pkg.sv
// Shared encodings for the rd/wt/ds read handshake: responder states,
// initiator states and the wait-counter width.
package read_hs_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    RSP_IDLE  = 2'd0,
    RSP_FETCH = 2'd1,
    RSP_STALL = 2'd2,
    RSP_HOLD  = 2'd3
  } rsp_state_e;

  typedef enum logic [1:0] {
    INI_IDLE = 2'd0,
    INI_READ = 2'd1,
    INI_WAIT = 2'd2,
    INI_DONE = 2'd3
  } ini_state_e;

  // True in the states where the responder may still be stalling the initiator.
  function automatic logic rsp_busy(input rsp_state_e s);
    return (s == RSP_FETCH) || (s == RSP_STALL);
  endfunction

endpackage

// File: rtl/rd_wait_cnt.sv
// Loadable 8-bit down-counter with zero flag. Exposes its next value so the
// owner can register outputs that depend on the count without extra latency.
module rd_wait_cnt
  import read_hs_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Next count: clear beats load beats decrement; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign cnt_nxt = cnt_d;
  assign zero    = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/read_responder.sv
// Target side of the rd/wt/ds read handshake. Fetches one word per
// transaction from a sync-read memory at an auto-incrementing pointer,
// stalls the initiator for WAIT_CYCLES via wt, presents the word with
// rvalid and retires on ds. Protocol violations pulse err.
module read_responder
  import read_hs_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int WAIT_CYCLES = 2,
  parameter int BASE_ADDR   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd,
  input  logic              ds,
  output logic              wt,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  input  logic              ptr_load,
  input  logic [ADDR_W-1:0] ptr_val,
  output logic              err
);

  rsp_state_e        state_d, state_q;
  logic [ADDR_W-1:0] ptr_d, ptr_q;
  logic [DATA_W-1:0] rdata_d, rdata_q;
  logic              wt_d, wt_q;
  logic              rvalid_d, rvalid_q;
  logic              err_d, err_q;
  logic              mem_en_s;
  logic              cnt_load_s, cnt_dec_s, cnt_clr_s, cnt_zero_s;
  logic [CNT_W-1:0]  cnt_s, cnt_nxt_s;

  rd_wait_cnt u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr_s),
    .load     (cnt_load_s),
    .load_val (CNT_W'(WAIT_CYCLES)),
    .dec      (cnt_dec_s),
    .cnt      (cnt_s),
    .cnt_nxt  (cnt_nxt_s),
    .zero     (cnt_zero_s)
  );

  // Next-state, pointer, capture and violation decode for the handshake.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rdata_d    = rdata_q;
    err_d      = 1'b0;
    cnt_load_s = 1'b0;
    cnt_dec_s  = 1'b0;
    cnt_clr_s  = 1'b0;
    mem_en_s   = 1'b0;
    case (state_q)
      RSP_IDLE: begin
        if (ds) begin
          err_d = 1'b1;                 // stray done strobe, nothing moves
        end else if (ptr_load) begin
          ptr_d = ptr_val;              // load wins; a held rd fetches next cycle
        end else if (rd) begin
          mem_en_s   = 1'b1;
          cnt_load_s = 1'b1;
          state_d    = RSP_FETCH;
        end else begin
          state_d = RSP_IDLE;
        end
      end
      RSP_FETCH, RSP_STALL: begin
        if (!rd) begin
          state_d   = RSP_IDLE;         // initiator went away mid-read
          cnt_clr_s = 1'b1;
          err_d     = 1'b1;
        end else if (ds) begin
          err_d = 1'b1;                 // early done: freeze this cycle
        end else begin
          if (state_q == RSP_FETCH) begin
            rdata_d = mem_rdata;
          end else begin
            rdata_d = rdata_q;
          end
          cnt_dec_s = !cnt_zero_s;
          // Count is never zero in STALL, so "<=1" covers both states.
          if (cnt_s <= 8'd1) begin
            state_d = RSP_HOLD;
          end else begin
            state_d = RSP_STALL;
          end
        end
      end
      RSP_HOLD: begin
        if (ds) begin
          ptr_d   = ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          state_d = RSP_IDLE;
          err_d   = rd;                 // rd with ds is flagged but still retires
        end else begin
          state_d = RSP_HOLD;
        end
      end
      default: begin
        state_d = RSP_IDLE;
      end
    endcase
    wt_d     = rsp_busy(state_d) && (cnt_nxt_s != 8'd0);
    rvalid_d = (state_d == RSP_HOLD);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RSP_IDLE;
      ptr_q    <= ADDR_W'(BASE_ADDR);
      rdata_q  <= {DATA_W{1'b0}};
      wt_q     <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rdata_q  <= rdata_d;
      wt_q     <= wt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  assign wt       = wt_q;
  assign rvalid   = rvalid_q;
  assign err      = err_q;
  assign rdata    = rdata_q;
  assign mem_en   = mem_en_s;
  assign mem_addr = ptr_q;

endmodule

// File: tb/tb_read_responder.sv
// Directed bench for read_responder: five instances with different wait
// lengths, each with its own sync-read memory port and initiator FSM.
module tb_read_responder;
  import read_hs_pkg::*;

  localparam int N = 5;

  function automatic int w_of(input int g);
    case (g)
      0:       return 2;
      1:       return 0;
      2:       return 3;
      3:       return 1;
      4:       return 5;
      default: return 2;
    endcase
  endfunction

  logic       clk = 1'b0;
  logic       rst;
  logic       man_rd [N];
  logic       man_ds [N];
  logic       man_ptr_load [N];
  logic [3:0] man_ptr_val [N];
  logic       start [N];
  logic       rd_s [N];
  logic       ds_s [N];
  logic       wt [N];
  logic       mem_en [N];
  logic [3:0] mem_addr [N];
  logic [7:0] mem_rdata [N];
  logic [7:0] rdata [N];
  logic       rvalid [N];
  logic       err [N];
  ini_state_e ini_q [N];
  logic [7:0] mem [16];
  logic [3:0] exp_ptr [N];
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    read_responder #(.DATA_W(8), .ADDR_W(4), .WAIT_CYCLES(w_of(g)), .BASE_ADDR(0)) u_dut (
      .clk(clk), .rst(rst), .rd(rd_s[g]), .ds(ds_s[g]), .wt(wt[g]),
      .mem_en(mem_en[g]), .mem_addr(mem_addr[g]), .mem_rdata(mem_rdata[g]),
      .rdata(rdata[g]), .rvalid(rvalid[g]), .ptr_load(man_ptr_load[g]),
      .ptr_val(man_ptr_val[g]), .err(err[g])
    );
  end

  // Handshake lines: manual drive OR'd with the initiator FSM.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      rd_s[k] = man_rd[k] | (ini_q[k] == INI_READ) | (ini_q[k] == INI_WAIT);
      ds_s[k] = man_ds[k] | (ini_q[k] == INI_DONE);
    end
  end

  // Sync-read memories and initiator FSMs.
  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (mem_en[k]) mem_rdata[k] <= mem[mem_addr[k]];
      if (rst) begin
        ini_q[k] <= INI_IDLE;
      end else begin
        case (ini_q[k])
          INI_IDLE: if (start[k]) ini_q[k] <= INI_READ;
          INI_READ: ini_q[k] <= INI_WAIT;
          INI_WAIT: if (!wt[k]) ini_q[k] <= INI_DONE;
          INI_DONE: ini_q[k] <= INI_IDLE;
          default:  ini_q[k] <= INI_IDLE;
        endcase
      end
    end
  end

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    next_cyc; next_cyc;
    @(negedge clk);
    n_checks++; if (wt[0] !== 1'b0) begin n_fail++; $display("FAIL reset_wt got %b want 0", wt[0]); end
    n_checks++; if (rvalid[0] !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %b want 0", rvalid[0]); end
    n_checks++; if (err[0] !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err[0]); end
    n_checks++; if (rdata[0] !== 8'h00) begin n_fail++; $display("FAIL reset_rdata got %h want 00", rdata[0]); end
    n_checks++; if (mem_addr[0] !== 4'h0) begin n_fail++; $display("FAIL reset_ptr got %h want 0", mem_addr[0]); end
    n_checks++; if (mem_en[0] !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en got %b want 0", mem_en[0]); end
    next_cyc;
    rst = 1'b0;
    for (int k = 0; k < N; k++) exp_ptr[k] = 4'h0;
  endtask

  // One complete manually-driven transaction on instance g.
  task automatic do_txn(input int g, input bit skip_first);
    int         w;
    logic [3:0] a;
    logic [7:0] d;
    w = w_of(g);
    a = exp_ptr[g];
    d = mem[a];
    if (!skip_first) begin
      next_cyc;
      man_rd[g] = 1'b1;
      man_ptr_load[g] = 1'b0;
      @(negedge clk);
      n_checks++; if (mem_en[g] !== 1'b1) begin n_fail++; $display("FAIL txn%0d_mem_en got %b want 1", g, mem_en[g]); end
      n_checks++; if (mem_addr[g] !== a) begin n_fail++; $display("FAIL txn%0d_mem_addr got %h want %h", g, mem_addr[g], a); end
    end
    for (int k = 1; k <= w; k++) begin
      next_cyc;
      @(negedge clk);
      n_checks++; if (wt[g] !== 1'b1) begin n_fail++; $display("FAIL txn%0d_wt_high cyc%0d got %b want 1", g, k, wt[g]); end
      n_checks++; if (rvalid[g] !== 1'b0) begin n_fail++; $display("FAIL txn%0d_rvalid_early got %b want 0", g, rvalid[g]); end
    end
    next_cyc;
    @(negedge clk);
    n_checks++; if (wt[g] !== 1'b0) begin n_fail++; $display("FAIL txn%0d_wt_low got %b want 0", g, wt[g]); end
    n_checks++; if (rvalid[g] !== 1'(w >= 1)) begin n_fail++; $display("FAIL txn%0d_rvalid_wait_exit got %b want %b", g, rvalid[g], (w >= 1)); end
    next_cyc;
    man_rd[g] = 1'b0;
    man_ds[g] = 1'b1;
    @(negedge clk);
    n_checks++; if (rvalid[g] !== 1'b1) begin n_fail++; $display("FAIL txn%0d_rvalid_done got %b want 1", g, rvalid[g]); end
    n_checks++; if (rdata[g] !== d) begin n_fail++; $display("FAIL txn%0d_rdata got %h want %h", g, rdata[g], d); end
    next_cyc;
    man_ds[g] = 1'b0;
    exp_ptr[g] = a + 4'd1;
    @(negedge clk);
    n_checks++; if (rvalid[g] !== 1'b0) begin n_fail++; $display("FAIL txn%0d_rvalid_after got %b want 0", g, rvalid[g]); end
    n_checks++; if (mem_addr[g] !== exp_ptr[g]) begin n_fail++; $display("FAIL txn%0d_ptr_inc got %h want %h", g, mem_addr[g], exp_ptr[g]); end
    n_checks++; if (err[g] !== 1'b0) begin n_fail++; $display("FAIL txn%0d_err got %b want 0", g, err[g]); end
  endtask

  task automatic test_basic_w2;
    do_txn(0, 1'b0);
  endtask

  task automatic test_no_wait;
    do_txn(1, 1'b0);
    do_txn(1, 1'b0);
  endtask

  task automatic test_ptr_load_wrap;
    next_cyc;
    man_ptr_load[0] = 1'b1;
    man_ptr_val[0] = 4'hF;
    man_rd[0] = 1'b1;
    @(negedge clk);
    n_checks++; if (mem_en[0] !== 1'b0) begin n_fail++; $display("FAIL load_beats_rd got %b want 0", mem_en[0]); end
    exp_ptr[0] = 4'hF;
    do_txn(0, 1'b0);
    do_txn(0, 1'b0);
  endtask

  task automatic test_abort;
    logic [3:0] a;
    a = exp_ptr[2];
    next_cyc; man_rd[2] = 1'b1;
    next_cyc;
    @(negedge clk);
    n_checks++; if (wt[2] !== 1'b1) begin n_fail++; $display("FAIL abort_wt_before got %b want 1", wt[2]); end
    next_cyc; man_rd[2] = 1'b0;
    next_cyc;
    @(negedge clk);
    n_checks++; if (wt[2] !== 1'b0) begin n_fail++; $display("FAIL abort_wt got %b want 0", wt[2]); end
    n_checks++; if (err[2] !== 1'b1) begin n_fail++; $display("FAIL abort_err got %b want 1", err[2]); end
    n_checks++; if (rvalid[2] !== 1'b0) begin n_fail++; $display("FAIL abort_rvalid got %b want 0", rvalid[2]); end
    n_checks++; if (mem_addr[2] !== a) begin n_fail++; $display("FAIL abort_ptr got %h want %h", mem_addr[2], a); end
    next_cyc;
    @(negedge clk);
    n_checks++; if (err[2] !== 1'b0) begin n_fail++; $display("FAIL abort_err_pulse got %b want 0", err[2]); end
    n_checks++; if (rvalid[2] !== 1'b0) begin n_fail++; $display("FAIL abort_rvalid_later got %b want 0", rvalid[2]); end
  endtask

  task automatic test_ds_idle;
    next_cyc; man_ds[0] = 1'b1;
    @(negedge clk);
    n_checks++; if (mem_en[0] !== 1'b0) begin n_fail++; $display("FAIL ds_idle_mem_en got %b want 0", mem_en[0]); end
    next_cyc; man_ds[0] = 1'b0;
    @(negedge clk);
    n_checks++; if (err[0] !== 1'b1) begin n_fail++; $display("FAIL ds_idle_err got %b want 1", err[0]); end
    n_checks++; if (mem_addr[0] !== exp_ptr[0]) begin n_fail++; $display("FAIL ds_idle_ptr got %h want %h", mem_addr[0], exp_ptr[0]); end
    next_cyc;
    @(negedge clk);
    n_checks++; if (err[0] !== 1'b0) begin n_fail++; $display("FAIL ds_idle_err_pulse got %b want 0", err[0]); end
    do_txn(0, 1'b0);
  endtask

  task automatic test_rst_mid;
    next_cyc; man_rd[0] = 1'b1;
    next_cyc;
    next_cyc; rst = 1'b1;
    @(negedge clk);
    n_checks++; if (wt[0] !== 1'b1) begin n_fail++; $display("FAIL rst_mid_stall_wt got %b want 1", wt[0]); end
    next_cyc; rst = 1'b0;
    for (int k = 0; k < N; k++) exp_ptr[k] = 4'h0;
    @(negedge clk);
    n_checks++; if (wt[0] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_wt got %b want 0", wt[0]); end
    n_checks++; if (rvalid[0] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rvalid got %b want 0", rvalid[0]); end
    n_checks++; if (mem_addr[0] !== 4'h0) begin n_fail++; $display("FAIL rst_mid_ptr got %h want 0", mem_addr[0]); end
    n_checks++; if (mem_en[0] !== 1'b1) begin n_fail++; $display("FAIL rst_mid_refetch got %b want 1", mem_en[0]); end
    do_txn(0, 1'b1);
  endtask

  task automatic test_initiator_done;
    int order [4];
    order[0] = 1; order[1] = 3; order[2] = 0; order[3] = 4;
    for (int i = 0; i < 4; i++) begin
      int         g;
      int         w;
      int         found;
      logic [3:0] a;
      g = order[i];
      w = w_of(g);
      a = exp_ptr[g];
      found = -1;
      next_cyc; start[g] = 1'b1;
      next_cyc; start[g] = 1'b0;
      for (int n = 0; n < 40 && found < 0; n++) begin
        @(negedge clk);
        if (ini_q[g] == INI_DONE) begin
          found = n;
          n_checks++; if (rvalid[g] !== 1'b1) begin n_fail++; $display("FAIL ini_w%0d_rvalid got %b want 1", w, rvalid[g]); end
          n_checks++; if (rdata[g] !== mem[a]) begin n_fail++; $display("FAIL ini_w%0d_rdata got %h want %h", w, rdata[g], mem[a]); end
        end else begin
          next_cyc;
        end
      end
      n_checks++; if (found != 2 + w) begin n_fail++; $display("FAIL ini_w%0d_done_cycle got %0d want %0d", w, found, 2 + w); end
      exp_ptr[g] = a + 4'd1;
      next_cyc; next_cyc;
      @(negedge clk);
      n_checks++; if (mem_addr[g] !== exp_ptr[g]) begin n_fail++; $display("FAIL ini_w%0d_ptr got %h want %h", w, mem_addr[g], exp_ptr[g]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'hA5 + 8'(i * 59);
    for (int k = 0; k < N; k++) begin
      man_rd[k] = 1'b0; man_ds[k] = 1'b0; man_ptr_load[k] = 1'b0;
      man_ptr_val[k] = 4'h0; start[k] = 1'b0; exp_ptr[k] = 4'h0;
    end
    test_reset;
    test_basic_w2;
    test_no_wait;
    test_ptr_load_wrap;
    test_abort;
    test_ds_idle;
    test_rst_mid;
    test_initiator_done;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
